ase_pcie_ss_dma_tag_tracker: RTL and testbench

- Tracks outstanding DMA read requests for the PCIe SS TLP emulator.
- Allocates tags from a free list and records each request's byte length.
- Consumes completion beats and retires a tag once all of its bytes have returned.
- Sits between the AFU-side read request path and the host completion generator; sized by the emulator's outstanding-read and RCB configuration.

---
 rtl/ase_pcie_ss_dma_tag_tracker.sv | 108 ++++++++++
 tb/tb_ase_pcie_ss_dma_tag_tracker.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ase_pcie_ss_dma_tag_tracker.sv
// ase_pcie_ss_dma_tag_tracker: DMA read tag free list, per-tag byte tracking and retirement (optional checks: ASE_PCIE_SS_TAG_ERR_CHK_EN)
module ase_pcie_ss_dma_tag_tracker #(
  parameter int MAX_OUTSTANDING  = 256,
  parameter int TAG_WIDTH        = $clog2(MAX_OUTSTANDING),
  parameter int MAX_RD_REQ_BYTES = 4096,
  parameter int LEN_WIDTH        = $clog2(MAX_RD_REQ_BYTES) + 1,
  parameter int RCB_BYTES        = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 init_done,
  input  logic                 alloc_req,
  input  logic [LEN_WIDTH-1:0] alloc_len,
  output logic                 alloc_rdy,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic                 cpl_valid,
  input  logic [TAG_WIDTH-1:0] cpl_tag,
  input  logic [LEN_WIDTH-1:0] cpl_bytes,
  output logic                 cpl_ready,
  output logic                 done_valid,
  output logic [TAG_WIDTH-1:0] done_tag,
`ifdef ASE_PCIE_SS_TAG_ERR_CHK_EN
  output logic [3:0]           err_flags,
`endif
  output logic [TAG_WIDTH:0]   num_outstanding
);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_RD_REQ_BYTES);
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t r_state, w_next;
  logic [TAG_WIDTH-1:0] r_fifo [MAX_OUTSTANDING];
  logic [LEN_WIDTH-1:0] r_rem [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] r_out;
  logic [TAG_WIDTH:0] r_wp, r_rp, w_free;
  logic w_run, w_fire, w_hit, w_final, w_push, w_bad_len;
  logic [TAG_WIDTH-1:0] w_push_tag;
  logic [LEN_WIDTH-1:0] w_len, w_cur_rem;
  assign w_free     = r_wp - r_rp;
  assign w_fire     = alloc_req && alloc_rdy;
  assign w_cur_rem  = r_rem[cpl_tag];
  assign w_hit      = cpl_valid && cpl_ready && r_out[cpl_tag];
  assign w_final    = w_hit && (cpl_bytes >= w_cur_rem);
  assign w_bad_len  = (alloc_len == '0) || (alloc_len > LEN_MAX);
  assign w_len      = w_bad_len ? LEN_MAX : alloc_len;
  // INIT pushes its own write pointer as the tag; RUN recycles the tag retired last cycle
  assign w_push     = (r_state == S_INIT) || done_valid;
  assign w_push_tag = (r_state == S_INIT) ? r_wp[TAG_WIDTH-1:0] : done_tag;
  // state register; reset always restarts the free-list fill
  always_ff @(posedge clk)
    r_state <= reset ? S_INIT : w_next;
  // next state and handshake outputs, all held low while reset is asserted
  always_comb begin
    w_next    = r_state;
    w_run     = !reset && (r_state == S_RUN);
    init_done = w_run;
    cpl_ready = w_run;
    alloc_rdy = w_run && (w_free != '0);
    alloc_tag = w_run ? r_fifo[r_rp[TAG_WIDTH-1:0]] : '0;
    if (r_state == S_INIT && r_wp[TAG_WIDTH-1:0] == TAG_WIDTH'(MAX_OUTSTANDING - 1)) w_next = S_RUN;
  end
  // free FIFO pointers; extra MSB distinguishes full from empty
  always_ff @(posedge clk)
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_fire) r_rp <= r_rp + 1'b1;
    end
  // free FIFO storage
  always_ff @(posedge clk)
    if (!reset && w_push) r_fifo[r_wp[TAG_WIDTH-1:0]] <= w_push_tag;
  // outstanding bits, retirement pulse and outstanding count
  always_ff @(posedge clk)
    if (reset) begin
      r_out           <= '0;
      done_valid      <= 1'b0;
      done_tag        <= '0;
      num_outstanding <= '0;
    end else begin
      if (w_fire) r_out[alloc_tag] <= 1'b1;
      if (w_final) r_out[cpl_tag] <= 1'b0;
      done_valid      <= w_final;
      done_tag        <= w_final ? cpl_tag : done_tag;
      num_outstanding <= num_outstanding + (TAG_WIDTH+1)'(w_fire) - (TAG_WIDTH+1)'(w_final);
    end
  // remaining bytes per tag; only meaningful while the tag is outstanding
  always_ff @(posedge clk) begin
    if (w_fire) r_rem[alloc_tag] <= w_len;
    if (w_hit && !w_final) r_rem[cpl_tag] <= w_cur_rem - cpl_bytes;
  end
`ifdef ASE_PCIE_SS_TAG_ERR_CHK_EN
  logic [3:0] w_err;
  assign w_err = {w_fire && w_bad_len,
                  w_hit && !w_final && ((cpl_bytes % LEN_WIDTH'(RCB_BYTES)) != '0),
                  w_hit && (cpl_bytes > w_cur_rem),
                  cpl_valid && cpl_ready && !r_out[cpl_tag]};
  // sticky protocol error flags with a report naming the offending tag
  always_ff @(posedge clk)
    if (reset) err_flags <= '0;
    else begin
      err_flags <= err_flags | w_err;
      if (w_err[0]) $display("tag_tracker: completion to non-outstanding tag %0d", cpl_tag);
      if (w_err[1]) $display("tag_tracker: completion overrun on tag %0d", cpl_tag);
      if (w_err[2]) $display("tag_tracker: non-RCB-aligned partial completion on tag %0d", cpl_tag);
      if (w_err[3]) $display("tag_tracker: illegal request length on tag %0d", alloc_tag);
    end
`endif
endmodule

// File: tb/tb_ase_pcie_ss_dma_tag_tracker.sv
// tb_ase_pcie_ss_dma_tag_tracker: directed self-checking bench for the DMA tag tracker
module tb_ase_pcie_ss_dma_tag_tracker;
  localparam int N  = 8;
  localparam int TW = 3;
  localparam int LW = 13;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_done, alloc_req, alloc_rdy, cpl_valid, cpl_ready, done_valid;
  logic [LW-1:0] alloc_len, cpl_bytes;
  logic [TW-1:0] alloc_tag, cpl_tag, done_tag;
  logic [TW:0] num_outstanding;
`ifdef ASE_PCIE_SS_TAG_ERR_CHK_EN
  logic [3:0] err_flags;
`endif
  int checks = 0;
  int failures = 0;
  ase_pcie_ss_dma_tag_tracker #(.MAX_OUTSTANDING(N)) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .alloc_req(alloc_req), .alloc_len(alloc_len), .alloc_rdy(alloc_rdy), .alloc_tag(alloc_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_bytes(cpl_bytes), .cpl_ready(cpl_ready),
    .done_valid(done_valid), .done_tag(done_tag),
`ifdef ASE_PCIE_SS_TAG_ERR_CHK_EN
    .err_flags(err_flags),
`endif
    .num_outstanding(num_outstanding)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cpl(input int tag, input int bytes);
    cpl_valid = 1'b1;
    cpl_tag   = TW'(tag);
    cpl_bytes = LW'(bytes);
  endtask
  initial begin
    alloc_req = 1'b0; alloc_len = '0; cpl_valid = 1'b0; cpl_tag = '0; cpl_bytes = '0;
    tick; tick;
    chk("rst_init_done", init_done, 0);
    chk("rst_alloc_rdy", alloc_rdy, 0);
    chk("rst_cpl_ready", cpl_ready, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_num", num_outstanding, 0);
    reset = 1'b0;
    repeat (7) tick;
    chk("init_not_done_7", init_done, 0);
    chk("init_alloc_rdy_7", alloc_rdy, 0);
    chk("init_cpl_ready_7", cpl_ready, 0);
    tick;
    chk("init_done_8", init_done, 1);
    chk("run_alloc_rdy", alloc_rdy, 1);
    chk("run_cpl_ready", cpl_ready, 1);
    chk("run_alloc_tag", alloc_tag, 0);
    for (int i = 0; i < N; i++) begin
      chk("alloc_order", alloc_tag, i);
      alloc_req = 1'b1; alloc_len = LW'(128);
      tick;
    end
    alloc_req = 1'b0;
    chk("full_alloc_rdy", alloc_rdy, 0);
    chk("full_num", num_outstanding, 8);
    cpl(3, 128); tick; cpl_valid = 1'b0;
    chk("ret3_done_valid", done_valid, 1);
    chk("ret3_done_tag", done_tag, 3);
    chk("ret3_not_yet_free", alloc_rdy, 0);
    chk("ret3_num", num_outstanding, 7);
    tick;
    chk("ret3_pulse_end", done_valid, 0);
    chk("ret3_free_rdy", alloc_rdy, 1);
    chk("ret3_free_tag", alloc_tag, 3);
    alloc_req = 1'b1; alloc_len = LW'(256); tick; alloc_req = 1'b0;
    chk("re3_num", num_outstanding, 8);
    chk("re3_rdy", alloc_rdy, 0);
    cpl(3, 64); tick;
    chk("t3_beat1", done_valid, 0);
    cpl(3, 64); tick;
    chk("t3_beat2", done_valid, 0);
    cpl(3, 128); tick; cpl_valid = 1'b0;
    chk("t3_beat3_valid", done_valid, 1);
    chk("t3_beat3_tag", done_tag, 3);
    chk("t3_num", num_outstanding, 7);
    tick;
    chk("t3_pulse_end", done_valid, 0);
    chk("t3_free_rdy", alloc_rdy, 1);
    chk("t3_free_tag", alloc_tag, 3);
    alloc_req = 1'b1; alloc_len = LW'(128); cpl(5, 128);
    tick;
    alloc_req = 1'b0; cpl_valid = 1'b0;
    chk("same_done_valid", done_valid, 1);
    chk("same_done_tag", done_tag, 5);
    chk("same_num", num_outstanding, 7);
    chk("same_rdy_empty", alloc_rdy, 0);
    tick;
    chk("same_rdy_after", alloc_rdy, 1);
    chk("same_tag_after", alloc_tag, 5);
    cpl(5, 64); tick;
    chk("stale_done_valid", done_valid, 0);
    chk("stale_num", num_outstanding, 7);
    cpl(1, 300); tick; cpl_valid = 1'b0;
    chk("overrun_done_valid", done_valid, 1);
    chk("overrun_done_tag", done_tag, 1);
    chk("overrun_num", num_outstanding, 6);
`ifdef ASE_PCIE_SS_TAG_ERR_CHK_EN
    chk("err_flags", err_flags, 4'b0011);
`endif
    tick;
    chk("fifo_head_5", alloc_tag, 5);
    alloc_req = 1'b1; alloc_len = '0; tick; alloc_req = 1'b0;
    chk("len0_num", num_outstanding, 7);
    chk("len0_next_tag", alloc_tag, 1);
    cpl(5, 4032); tick;
    chk("clamp_partial", done_valid, 0);
    cpl(5, 64); tick; cpl_valid = 1'b0;
    chk("clamp_final_valid", done_valid, 1);
    chk("clamp_final_tag", done_tag, 5);
    chk("clamp_num", num_outstanding, 6);
    reset = 1'b1; cpl(2, 128); tick;
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_alloc_rdy", alloc_rdy, 0);
    chk("mid_rst_cpl_ready", cpl_ready, 0);
    chk("mid_rst_done_valid", done_valid, 0);
    chk("mid_rst_done_tag", done_tag, 0);
    chk("mid_rst_alloc_tag", alloc_tag, 0);
    chk("mid_rst_num", num_outstanding, 0);
`ifdef ASE_PCIE_SS_TAG_ERR_CHK_EN
    chk("mid_rst_err", err_flags, 0);
`endif
    reset = 1'b0;
    repeat (8) tick;
    chk("reinit_done", init_done, 1);
    chk("reinit_alloc_tag", alloc_tag, 0);
    chk("reinit_num", num_outstanding, 0);
    tick; cpl_valid = 1'b0;
    chk("reinit_stale_done", done_valid, 0);
    chk("reinit_stale_num", num_outstanding, 0);
    tick;
    chk("reinit_head", alloc_tag, 0);
    chk("reinit_rdy", alloc_rdy, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
